// File: rtl/bitserial_and15.sv
// Bit-serial 15-bit AND: operands are latched on accept, then one result bit is
// produced per clock, LSB first, with a valid/ready handshake on both sides.
module bitserial_and15 (
  input  logic        clock,
  input  logic        reset,
  input  logic [14:0] a,
  input  logic [14:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [14:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [14:0] a_reg;
  logic [14:0] b_reg;
  logic [14:0] res;
  logic [14:0] bit_sel;
  logic [14:0] res_next;

  // One-hot select of the bit being computed this cycle.
  for (genvar gi = 0; gi < 15; gi++) begin : g_sel
    assign bit_sel[gi] = (cnt == 4'(gi));
  end

  // res is cleared on accept, so OR-ing in the selected bit is a plain write.
  assign res_next = res | (a_reg & b_reg & bit_sel);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      a_reg <= 15'd0;
      b_reg <= 15'd0;
      res   <= 15'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            res   <= 15'd0;
            cnt   <= 4'd0;
            state <= RUN;
          end
        end
        RUN: begin
          res <= res_next;
          if (cnt == 4'd14) begin
            cnt   <= 4'd0;
            state <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign out       = res;

endmodule

// File: doc/bitserial_and15.md
BITSERIAL_AND15 -- requirements
Module: bitserial_and15

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clock  input  1  Rising-edge clock for all state.
REQ-003 reset  input  1  Synchronous active-high reset, sampled on the rising edge of clock.
REQ-004 a  input  15  Operand word A, sampled only on the accept edge.
REQ-005 b  input  15  Operand word B, sampled only on the accept edge.
REQ-006 in_valid  input  1  Producer offers a and b.
REQ-007 in_ready  output  1  Block can accept operands.
REQ-008 out  output  15  Result word, out[i] = a[i] and b[i].
REQ-009 out_valid  output  1  out holds a completed result.
REQ-010 out_ready  input  1  Consumer takes the result.
REQ-011 busy  output  1  High while the block is serially computing (RUN state).

Function
REQ-012 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-013 in_ready SHALL be 1 in IDLE only; busy SHALL be 1 in RUN only; out_valid SHALL be 1 in DONE only (all three are decoded from state).
REQ-014 Accept occurs on a rising edge where state=IDLE and in_valid=1.
- On accept: a_reg <= a, b_reg <= b, res <= 0, cnt <= 0, state <= RUN.
REQ-015 In RUN, each edge SHALL compute exactly one bit, LSB first.
- Per edge: res[cnt] <= a_reg[cnt] and b_reg[cnt]; cnt <= cnt+1.
- cnt is a 4-bit counter, range 0..14; it never reaches 15 in RUN.
REQ-016 On the RUN edge with cnt=14, state SHALL become DONE and cnt SHALL return to 0.
REQ-017 Latency is fixed. If accept is edge E0, bits 0..14 are written at E1..E15, and out_valid is first high after E15. That is 15 cycles, independent of data.
REQ-018 out SHALL be driven from res, which is registered. out is don't-care (but stable) while out_valid=0.
REQ-019 In DONE, out and out_valid SHALL stay stable until an edge where out_ready=1; on that edge state becomes IDLE.
REQ-020 Handshake boundary cases:
- There is no same-cycle result handoff and re-accept. in_ready rises the cycle after the out_ready handshake.
- Minimum transaction period is 17 cycles.
REQ-021 Changes on a and b after the accept edge SHALL NOT affect the result.
REQ-022 in_valid asserted in RUN or DONE SHALL be ignored, because in_ready=0. No operands are latched.
REQ-023 out_ready asserted outside DONE SHALL have no effect.
REQ-024 X/unused bit: operands are 15 bits wide; no bit 15 exists or is computed.

Reset
REQ-025 When reset=1 on an edge, the block SHALL enter this state regardless of any other input:
- state=IDLE
- cnt=0
- res=0, so out=0x0000
- a_reg=0 and b_reg=0
- out_valid=0, busy=0, in_ready=1 (from the next cycle)
REQ-026 Reset SHALL take priority over accept, RUN progress and DONE handoff. Reset in RUN or DONE discards the operation in progress with no partial output.
REQ-027 After reset deasserts, the first edge with in_valid=1 SHALL be a valid accept.

Verification
REQ-028 Full ones: a=0x7FFF, b=0x7FFF, in_valid for 1 cycle, out_ready=1 -> busy high for 15 cycles, out_valid high exactly 15 cycles after accept with out=0x7FFF, in_ready high the following cycle.
REQ-029 Pattern data, back to back:
- a=0x5555, b=0x7FFF -> out=0x5555.
- Then a=0x2AAA, b=0x5555 -> out=0x0000.
- Then a=0x4001, b=0x7FFF -> out=0x4001 (MSB/LSB edge bits).
- Accepts are exactly 17 cycles apart.
REQ-030 Backpressure: a=0x1234, b=0x0FF0, out_ready=0 for 5 cycles after out_valid -> out=0x0230 stable and in_ready=0 throughout; out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
REQ-031 Reset mid-RUN: accept a=0x7FFF, b=0x7FFF, assert reset at cycle 7 of RUN -> out=0x0000, out_valid=0, busy=0 the next cycle. A new accept then returns the correct result.
REQ-032 Input isolation: accept a=0x00FF, b=0x0F0F, then drive a=0x7FFF, b=0x7FFF and hold in_valid=1 during RUN -> out=0x000F, and only one accept occurs.
REQ-033 Reset in DONE with out_ready=0 -> out_valid=0 and out=0x0000 next cycle; no handshake is recorded.
